// File: rtl/e_syncerr_213_if.sv
// Trellis-stage bus for the sync-error detector: eight path metrics and a stage
// strobe go in; the best state, its metric and the out-of-sync flag come out.
interface e_syncerr_213_if #(
  parameter int W = 4
);
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [W-1:0] in3;
  logic [W-1:0] in4;
  logic [W-1:0] in5;
  logic [W-1:0] in6;
  logic [W-1:0] in7;
  logic         we;
  logic [3:0]   stage;
  logic [2:0]   min_state;
  logic [W-1:0] min_metric;
  logic         error;

  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7, we, stage,
    input  min_state, min_metric, error
  );

  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7, we, stage,
    output min_state, min_metric, error
  );
endinterface

// File: rtl/e_syncerr_213.sv
// Viterbi out-of-sync detector: tracks how often the best-metric state changes
// within a traceback window and flags loss of sync at each window end.
module e_syncerr_213 #(
  parameter int W      = 4,
  parameter int T      = 12,
  parameter int M      = 2,
  parameter int THRESH = 4
) (
  input  logic             clock,
  input  logic             reset,
  e_syncerr_213_if.slave   bus
);

  localparam logic [3:0] M_L      = 4'(M);
  localparam logic [3:0] T_L      = 4'(T);
  localparam logic [3:0] THRESH_L = 4'(THRESH);

  logic [W-1:0] w_in [8];
  logic [2:0]   w_min_state;
  logic [W-1:0] w_min_metric;
  logic [3:0]   w_cnt_inc;

  logic [2:0]   r_prev_state;
  logic [3:0]   r_chg_cnt;
  logic         r_error;

  assign w_in[0] = bus.in0;
  assign w_in[1] = bus.in1;
  assign w_in[2] = bus.in2;
  assign w_in[3] = bus.in3;
  assign w_in[4] = bus.in4;
  assign w_in[5] = bus.in5;
  assign w_in[6] = bus.in6;
  assign w_in[7] = bus.in7;

  // Strict less-than scan from index 0 so ties resolve to the lowest index.
  always_comb begin
    w_min_state  = 3'd0;
    w_min_metric = w_in[0];
    for (int i = 1; i < 8; i++) begin
      if (w_in[i] < w_min_metric) begin
        w_min_metric = w_in[i];
        w_min_state  = 3'(i);
      end
    end
  end

  always_comb begin
    w_cnt_inc = r_chg_cnt;
    if ((w_min_state != r_prev_state) && (r_chg_cnt != 4'd15))
      w_cnt_inc = r_chg_cnt + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_state <= 3'd0;
      r_chg_cnt    <= 4'd0;
      r_error      <= 1'b0;
    end else if (bus.we) begin
      r_prev_state <= w_min_state;
      if (bus.stage <= M_L) begin
        r_chg_cnt <= 4'd0;
      end else if (bus.stage < T_L) begin
        r_chg_cnt <= w_cnt_inc;
      end else begin
        // Window end (stages past T alias to T): verdict includes this edge.
        r_error   <= (w_cnt_inc >= THRESH_L);
        r_chg_cnt <= 4'd0;
      end
    end
  end

  assign bus.min_state  = w_min_state;
  assign bus.min_metric = w_min_metric;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_e_syncerr_213.sv
// Directed bench for e_syncerr_213: min-finder patterns, window verdicts,
// idle cycles, over-range stage and asynchronous reset mid-window.
module tb_e_syncerr_213;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] tin [8];
  int         n_cmp = 0;
  int         n_err = 0;

  e_syncerr_213_if #(.W(4)) bus ();

  assign bus.in0 = tin[0];
  assign bus.in1 = tin[1];
  assign bus.in2 = tin[2];
  assign bus.in3 = tin[3];
  assign bus.in4 = tin[4];
  assign bus.in5 = tin[5];
  assign bus.in6 = tin[6];
  assign bus.in7 = tin[7];

  e_syncerr_213 #(.W(4), .T(12), .M(2), .THRESH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_min(input int idx);
    for (int i = 0; i < 8; i++) tin[i] = 4'd15;
    tin[idx] = 4'd0;
  endtask

  task automatic step(input logic [3:0] stg, input int idx);
    bus.we    = 1'b1;
    bus.stage = stg;
    set_min(idx);
    @(posedge clock);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic idle(input int idx);
    bus.we    = 1'b0;
    bus.stage = 4'd7;
    set_min(idx);
    @(posedge clock);
    #1;
  endtask

  // Runs stages 0..12 (last stage index overridable), optional idle cycles between.
  task automatic window(input int seq [13], input logic [3:0] last_stg, input bit gaps);
    for (int s = 0; s < 13; s++) begin
      step((s == 12) ? last_stg : 4'(s), seq[s]);
      if (gaps) idle(7);
    end
  endtask

  initial begin
    bus.we    = 1'b0;
    bus.stage = 4'd0;
    tin = '{4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    #2;
    chk("rst_error", {7'd0, bus.error}, 8'd0);
    chk("minst_a", {5'd0, bus.min_state}, 8'd0);
    chk("minmet_a", {4'd0, bus.min_metric}, 8'd0);
    tin = '{4'd9, 4'd9, 4'd3, 4'd7, 4'd3, 4'd8, 4'd9, 4'd9};
    #1;
    chk("minst_b", {5'd0, bus.min_state}, 8'd2);
    chk("minmet_b", {4'd0, bus.min_metric}, 8'd3);
    tin = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    #1;
    chk("minst_all15", {5'd0, bus.min_state}, 8'd0);
    chk("minmet_all15", {4'd0, bus.min_metric}, 8'd15);
    tin[7] = 4'd14;
    #1;
    chk("minst_in7", {5'd0, bus.min_state}, 8'd7);
    chk("minmet_in7", {4'd0, bus.min_metric}, 8'd14);

    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    window('{5,5,5,5,5,5,5,5,5,5,5,5,5}, 4'd12, 1'b0);
    chk("const5_err", {7'd0, bus.error}, 8'd0);

    window('{5,5,5,1,2,1,2,1,2,1,2,1,2}, 4'd12, 1'b0);
    chk("alt10_err", {7'd0, bus.error}, 8'd1);

    for (int s = 0; s < 12; s++) step(4'(s), 0);
    chk("hold_mid", {7'd0, bus.error}, 8'd1);
    step(4'd12, 0);
    chk("const_clear", {7'd0, bus.error}, 8'd0);

    window('{0,0,0,1,1,2,2,2,3,3,3,3,4}, 4'd12, 1'b1);
    chk("chg4_err", {7'd0, bus.error}, 8'd1);

    window('{4,4,4,5,6,7,7,7,7,7,7,7,7}, 4'd12, 1'b1);
    chk("chg3_err", {7'd0, bus.error}, 8'd0);

    window('{5,5,5,1,2,1,2,1,2,1,2,1,2}, 4'd12, 1'b0);
    chk("alt10_again", {7'd0, bus.error}, 8'd1);

    step(4'd0, 5); step(4'd1, 5); step(4'd2, 5);
    step(4'd3, 1); step(4'd4, 2); step(4'd5, 5);
    chk("pre_rst_err", {7'd0, bus.error}, 8'd1);
    reset = 1'b0;
    #2;
    chk("async_rst", {7'd0, bus.error}, 8'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_rel", {7'd0, bus.error}, 8'd0);
    step(4'd6, 0); step(4'd7, 1); step(4'd8, 2); step(4'd9, 3);
    step(4'd10, 3); step(4'd11, 3); step(4'd12, 3);
    chk("restart_cnt", {7'd0, bus.error}, 8'd0);

    window('{0,0,0,1,2,3,4,4,4,4,4,4,4}, 4'd13, 1'b0);
    chk("stage13_end", {7'd0, bus.error}, 8'd1);
    window('{4,4,4,4,4,4,4,4,4,4,4,4,4}, 4'd12, 1'b0);
    chk("after13_clr", {7'd0, bus.error}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
